qnigma_tcp_tx_sched: RTL
========================

Name: qnigma_tcp_tx_sched

Overview:
- Sequencing controller for the TCP transmit payload streamer. Owns the send window pointers (una, nxt).
- Decides when to request a payload packet, and with what seq/len, from:
  - buffered data count;
  - remote window;
  - MSS;
  - a flush timer.
- Processes incoming ACKs, reports free TX RAM space to the upstream writer, and performs go-back-N retransmission on timeout.

Parameters:
D, 10, TX data RAM address width; buffer holds 2^D bytes
MSS, 536, maximum payload bytes per packet (1..2^D)
FLUSH_TICKS, 1000, clk cycles a partial segment may wait before being sent
RTO_TICKS, 50000, clk cycles without ACK progress before retransmission

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
connected  in  1  connection established; low forces CLOSED
init_seq  in  32  first payload seq, sampled on connected rising edge
wr_ptr  in  32  seq one past last byte written into TX RAM
ack_val  in  1  one-cycle strobe: ack_num valid
ack_num  in  32  remote acknowledgement number
rem_wnd  in  16  remote advertised window
force  in  1  one-cycle strobe: send any unsent data now
pend  out  1  packet pending, to streamer
seq  out  32  first byte seq of requested packet
len  out  16  payload length of requested packet
idle  in  1  streamer idle
sent  in  1  one-cycle strobe: packet completely sent
una  out  32  oldest unacknowledged seq
nxt  out  32  next seq to send
free  out  D+1  free RAM bytes = 2^D - (wr_ptr - una)
retx  out  1  one-cycle strobe on retransmission
retx_cnt  out  8  retransmissions since connect, saturating at 255

Behaviour:
- Reset values (async): state CLOSED, pend 0, seq 0, len 0, una 0, nxt 0, retx 0, retx_cnt 0, timers 0. free is combinational.
- All seq arithmetic is mod 2^32:
  - unsent = wr_ptr - nxt
  - flight = nxt - una
  - usable = rem_wnd - flight, saturating at 0 when flight >= rem_wnd
  - cand = min(unsent, usable, MSS), 16 bit
- CLOSED: pend 0. On connected 0->1: una <= nxt <= init_seq, retx_cnt <= 0, go to READY.
- READY:
  - Flush timer counts while 0 < unsent < MSS and cand > 0; it clears whenever cand == 0, and on each send.
  - Send condition: cand == MSS, OR (cand > 0 AND (flush timer == FLUSH_TICKS-1 OR force)).
  - On send: seq <= nxt, len <= cand, pend <= 1, go to REQ.
- REQ: hold pend, seq, len. When idle == 0 (streamer accepted): pend <= 0, go to BUSY.
- BUSY: wait for sent. Then nxt <= seq + len, go to READY. seq/len hold until the next request.
- ACK processing, in READY/REQ/BUSY:
  - On ack_val, accept only if 0 < (ack_num - una) <= (nxt - una). Accepted: una <= ack_num, RTO timer cleared.
  - Otherwise ignore: covers duplicate, old, and beyond-nxt ACKs.
  - An ACK arriving with sent in the same cycle uses the pre-update nxt.
- Disconnect: connected low in any state -> CLOSED next cycle, pend 0. seq/len/una/nxt hold. An in-flight streamer packet is not aborted.
- free:
  - Never exceeds 2^D.
  - wr_ptr must not advance beyond una + 2^D; if it does, free is 0 (saturating) and the behaviour is otherwise undefined.
- wr_ptr wraparound through 0xFFFFFFFF behaves identically to any other value.
- force in REQ/BUSY is dropped, not queued.

Optional Feature:
- Macro: QNIGMA_TCP_RETX_EN.
- Defined:
  - RTO timer counts in READY while flight > 0 and clears on accepted ACK.
  - At RTO_TICKS-1: nxt <= una, retx pulses 1 cycle, retx_cnt += 1 (saturating), timer cleared.
  - If the timer expires in REQ/BUSY, the rewind is deferred to the first READY cycle.
- Undefined: no RTO timer; retx tied 0, retx_cnt tied 0; una advances only via ACKs.

Test Plan:
- Connect with init_seq=0x1000, wr_ptr=0x1000+600, rem_wnd=4096 -> pend with seq=0x1000, len=536. After sent: nxt=0x1218; 64 bytes then flushed after FLUSH_TICKS with seq=0x1218, len=64.
- wr_ptr=init+100, rem_wnd=40 -> len=40; further sends blocked (usable 0). ack_num=init+40 with rem_wnd=40 -> next packet len=40.
- ACK checks: ack_num=una (dup) ignored; ack_num=nxt+1 ignored; ack_num=nxt -> una=nxt and free=2^D when wr_ptr=nxt.
- init_seq=0xFFFFFF00, 512 bytes buffered -> single packet len=512 spanning the wrap; after ACK 0x00000100, una=0x100 and free=1024.
- QNIGMA_TCP_RETX_EN: send 536, withhold ACK -> retx pulse after RTO_TICKS; nxt=una; resend with the same seq/len; retx_cnt=1.
- Drop connected during BUSY -> pend stays 0, state CLOSED. Reconnect with new init_seq -> una=nxt=init_seq, retx_cnt=0.

Source files
------------

// File: rtl/qnigma_tcp_tx_sched.sv
// TCP transmit sequencing: send-window pointers, packet requests, ACK tracking, free space.
// Optional go-back-N retransmission timer enabled by defining QNIGMA_TCP_RETX_EN.
module qnigma_tcp_tx_sched #(
    parameter int D           = 10,
    parameter int MSS         = 536,
    parameter int FLUSH_TICKS = 1000,
    parameter int RTO_TICKS   = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          connected,
    input  logic [31:0]   init_seq,
    input  logic [31:0]   wr_ptr,
    input  logic          ack_val,
    input  logic [31:0]   ack_num,
    input  logic [15:0]   rem_wnd,
    input  logic          force_send,
    output logic          pend,
    output logic [31:0]   seq,
    output logic [15:0]   len,
    input  logic          idle,
    input  logic          sent,
    output logic [31:0]   una,
    output logic [31:0]   nxt,
    output logic [D:0]    free,
    output logic          retx,
    output logic [7:0]    retx_cnt
);
    localparam logic [15:0] MSS16 = 16'(MSS);
    localparam int FW = $clog2(FLUSH_TICKS + 1);

    typedef enum logic [1:0] {CLOSED, READY, REQ, BUSY} state_t;

    state_t        state;
    logic          connected_d;
    logic [FW-1:0] flush_cnt;

    logic [31:0] unsent, flight, ack_off, buffered;
    logic [15:0] usable, lim, cand;
    logic        ack_ok, partial, flush_hit, send_now, connect_edge, rewind;

    always_comb begin
        unsent       = wr_ptr - nxt;
        flight       = nxt - una;
        usable       = (flight >= {16'd0, rem_wnd}) ? 16'd0 : rem_wnd - flight[15:0];
        lim          = (usable < MSS16) ? usable : MSS16;
        cand         = (unsent < {16'd0, lim}) ? unsent[15:0] : lim;
        ack_off      = ack_num - una;
        ack_ok       = ack_val && (state != CLOSED) && (ack_off != 32'd0) && (ack_off <= flight);
        partial      = (unsent != 32'd0) && (unsent < 32'(MSS));
        flush_hit    = (flush_cnt == FW'(FLUSH_TICKS - 1));
        send_now     = (cand == MSS16) || ((cand != 16'd0) && (flush_hit || force_send));
        connect_edge = connected && !connected_d && (state == CLOSED);
        // Writer overrun past una + 2^D saturates to zero rather than wrapping.
        buffered     = wr_ptr - una;
        free         = (buffered > 32'(1 << D)) ? '0 : (D+1)'(32'(1 << D) - buffered);
    end

`ifdef QNIGMA_TCP_RETX_EN
    localparam int RW = $clog2(RTO_TICKS + 1);
    logic [RW-1:0] rto_cnt;
    logic          retx_pend;
    logic          rto_hit;

    always_comb begin
        rto_hit = (rto_cnt == RW'(RTO_TICKS - 1));
        // Expiry outside READY is parked in retx_pend and replayed on the first READY cycle.
        rewind  = (state == READY) && connected && !ack_ok &&
                  (retx_pend || (rto_hit && flight != 32'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rto_cnt   <= '0;
            retx_pend <= 1'b0;
            retx      <= 1'b0;
            retx_cnt  <= 8'd0;
        end else begin
            retx <= 1'b0;
            if (!connected) begin
                rto_cnt   <= '0;
                retx_pend <= 1'b0;
            end else if (connect_edge) begin
                rto_cnt   <= '0;
                retx_pend <= 1'b0;
                retx_cnt  <= 8'd0;
            end else if (state != CLOSED) begin
                if (rewind) begin
                    retx      <= 1'b1;
                    retx_cnt  <= (retx_cnt == 8'hFF) ? 8'hFF : retx_cnt + 8'd1;
                    retx_pend <= 1'b0;
                    rto_cnt   <= '0;
                end else if (ack_ok || flight == 32'd0) begin
                    rto_cnt   <= '0;
                    retx_pend <= 1'b0;
                end else if (rto_hit) begin
                    rto_cnt   <= '0;
                    retx_pend <= 1'b1;
                end else begin
                    rto_cnt <= rto_cnt + RW'(1);
                end
            end
        end
    end
`else
    assign rewind   = 1'b0;
    assign retx     = 1'b0;
    assign retx_cnt = 8'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= CLOSED;
            connected_d <= 1'b0;
            pend        <= 1'b0;
            seq         <= 32'd0;
            len         <= 16'd0;
            una         <= 32'd0;
            nxt         <= 32'd0;
            flush_cnt   <= '0;
        end else begin
            connected_d <= connected;
            if (!connected) begin
                state     <= CLOSED;
                pend      <= 1'b0;
                flush_cnt <= '0;
            end else begin
                if (ack_ok)
                    una <= ack_num;
                case (state)
                    CLOSED: begin
                        if (connect_edge) begin
                            una   <= init_seq;
                            nxt   <= init_seq;
                            state <= READY;
                        end
                    end
                    READY: begin
                        if (rewind) begin
                            nxt       <= una;
                            flush_cnt <= '0;
                        end else if (send_now) begin
                            seq       <= nxt;
                            len       <= cand;
                            pend      <= 1'b1;
                            flush_cnt <= '0;
                            state     <= REQ;
                        end else if (cand == 16'd0) begin
                            flush_cnt <= '0;
                        end else if (partial) begin
                            flush_cnt <= flush_cnt + FW'(1);
                        end
                    end
                    REQ: begin
                        if (!idle) begin
                            pend  <= 1'b0;
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (sent) begin
                            nxt   <= seq + {16'd0, len};
                            state <= READY;
                        end
                    end
                    default: state <= CLOSED;
                endcase
            end
        end
    end
endmodule
